// File: rtl/header_prepender.sv
// Prepends a runtime-length byte header to every packet on a valid/ready stream.
// Payload is realigned through a carry register when the header length is not a bus-width multiple.
module header_prepender #(
  parameter int DATA_WIDTH    = 128,
  parameter int MAX_HDR_BYTES = 32,
  localparam int BYTES        = DATA_WIDTH / 8,
  localparam int EW           = $clog2(BYTES),
  localparam int LW           = $clog2(MAX_HDR_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [EW-1:0]              in_empty,
  output logic                       in_ready,
  input  logic [MAX_HDR_BYTES*8-1:0] hdr_data,
  input  logic [LW-1:0]              hdr_len,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [EW-1:0]              out_empty,
  input  logic                       out_ready,
  output logic                       err_sop
);

  localparam int HW   = MAX_HDR_BYTES * 8;
  localparam int MAXH = MAX_HDR_BYTES / BYTES;
  localparam int KW   = $clog2(MAXH + 2);

  typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         hdr_q, hdr_d;
  logic [KW-1:0]         hBeats_q, hBeats_d;
  logic [KW-1:0]         k_q, k_d;
  logic [EW-1:0]         rem_q, rem_d;
  logic [DATA_WIDTH-1:0] carry_q, carry_d;
  logic [DATA_WIDTH-1:0] beat_q, beat_d;
  logic [EW-1:0]         empty_q, empty_d;
  logic                  first_q, first_d;

  logic [LW-1:0]         lenIn;
  logic [KW-1:0]         hIn;
  logic [EW-1:0]         rIn;
  logic                  needFlush;
  int                    dataShift;

  // Header beat k: bytes [k*BYTES .. k*BYTES+BYTES-1], zero beyond the header vector.
  function automatic logic [DATA_WIDTH-1:0] hdrBeat(input logic [HW-1:0] h, input logic [KW-1:0] k);
    logic [HW+DATA_WIDTH-1:0] ext;
    ext = {h, {DATA_WIDTH{1'b0}}} << (int'(k) * DATA_WIDTH);
    return ext[HW+DATA_WIDTH-1 -: DATA_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] topMask(input logic [EW-1:0] n);
    return ~({DATA_WIDTH{1'b1}} >> {n, 3'b000});
  endfunction

  always_comb begin
    lenIn     = (int'(hdr_len) > MAX_HDR_BYTES) ? LW'(MAX_HDR_BYTES) : hdr_len;
    hIn       = KW'(int'(lenIn) / BYTES);
    rIn       = EW'(int'(lenIn) % BYTES);
    dataShift = (BYTES - int'(rem_q)) * 8;
    needFlush = in_eop && (rem_q > in_empty);

    state_d  = state_q;
    hdr_d    = hdr_q;
    hBeats_d = hBeats_q;
    k_d      = k_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    beat_d   = beat_q;
    empty_d  = empty_q;
    first_d  = first_q;

    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = '0;
    err_sop   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = in_valid & ~in_sop;
        err_sop  = in_valid & ~in_sop;
        if (in_valid && in_sop) begin
          hdr_d    = hdr_data;
          hBeats_d = hIn;
          rem_d    = rIn;
          k_d      = '0;
          first_d  = 1'b1;
          if (hIn != '0) begin
            beat_d  = hdrBeat(hdr_data, '0);
            carry_d = '0;
            state_d = HDR;
          end else begin
            carry_d = hdrBeat(hdr_data, '0) & topMask(rIn);
            state_d = DATA;
          end
        end
      end

      HDR: begin
        out_valid = 1'b1;
        out_data  = beat_q;
        out_sop   = first_q;
        if (out_ready) begin
          first_d = 1'b0;
          if (k_q == hBeats_q - KW'(1)) begin
            carry_d = hdrBeat(hdr_q, hBeats_q) & topMask(rem_q);
            state_d = DATA;
          end else begin
            k_d    = k_q + KW'(1);
            beat_d = hdrBeat(hdr_q, k_q + KW'(1));
          end
        end
      end

      // Carry bytes sit on top, the head of in_data fills the rest of the beat.
      DATA: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        out_data  = carry_q | (in_data >> {rem_q, 3'b000});
        out_sop   = first_q & in_valid;
        out_eop   = in_valid & in_eop & ~needFlush;
        out_empty = out_eop ? (in_empty - rem_q) : '0;
        if (in_valid && out_ready) begin
          first_d = 1'b0;
          carry_d = in_data << dataShift;
          if (in_eop) begin
            carry_d = '0;
            if (needFlush) begin
              beat_d  = in_data << dataShift;
              empty_d = EW'(BYTES + int'(in_empty) - int'(rem_q));
              state_d = FLUSH;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      FLUSH: begin
        out_valid = 1'b1;
        out_data  = beat_q;
        out_eop   = 1'b1;
        out_empty = empty_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_sop   = 1'b0;
      out_eop   = 1'b0;
      out_empty = '0;
      err_sop   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hdr_q    <= '0;
      hBeats_q <= '0;
      k_q      <= '0;
      rem_q    <= '0;
      carry_q  <= '0;
      beat_q   <= '0;
      empty_q  <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      hBeats_q <= hBeats_d;
      k_q      <= k_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      beat_q   <= beat_d;
      empty_q  <= empty_d;
      first_q  <= first_d;
    end
  end

endmodule

// File: tb/tb_header_prepender.sv
// Self-checking bench for header_prepender (32-bit bus, 8-byte max header):
// a byte-level reference model predicts every output beat.
module tb_header_prepender;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop;
  logic [1:0]  in_empty;
  logic        in_ready;
  logic [63:0] hdr_data;
  logic [3:0]  hdr_len;
  logic [31:0] out_data;
  logic        out_valid, out_sop, out_eop;
  logic [1:0]  out_empty;
  logic        out_ready;
  logic        err_sop;

  always #5 clk = ~clk;

  header_prepender #(.DATA_WIDTH(32), .MAX_HDR_BYTES(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .hdr_data(hdr_data), .hdr_len(hdr_len),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_ready(out_ready), .err_sop(err_sop)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  beat_t       expQ[$];
  beat_t       inQ[$];
  logic [7:0]  payQ[$];
  int          total = 0;
  int          bad = 0;
  bit          monEn = 1'b0;
  bit          trackEn = 1'b0;
  int          readyMode = 1;
  logic [63:0] curHdr;
  logic [3:0]  curLen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: the output packet is simply header bytes then payload bytes, cut into beats.
  task automatic buildPacket();
    logic [7:0] all[$];
    int    L, n, nb, m;
    beat_t b;
    L = (curLen > 4'd8) ? 8 : int'(curLen);
    for (int i = 0; i < L; i++) all.push_back(curHdr[63-8*i -: 8]);
    foreach (payQ[i]) all.push_back(payQ[i]);
    n  = all.size();
    nb = (n + NB - 1) / NB;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      for (int j = 0; j < NB; j++)
        if (k*NB + j < n) b.data[31-8*j -: 8] = all[k*NB + j];
      b.sop   = (k == 0);
      b.eop   = (k == nb - 1);
      b.empty = b.eop ? 2'(nb*NB - n) : 2'd0;
      expQ.push_back(b);
    end
    inQ.delete();
    m  = payQ.size();
    nb = (m + NB - 1) / NB;
    for (int k = 0; k < nb; k++) begin
      b.data = $urandom;
      for (int j = 0; j < NB; j++)
        if (k*NB + j < m) b.data[31-8*j -: 8] = payQ[k*NB + j];
      b.sop   = (k == 0);
      b.eop   = (k == nb - 1);
      b.empty = b.eop ? 2'(nb*NB - m) : 2'd0;
      inQ.push_back(b);
    end
  endtask

  // Drives inQ as one packet; header inputs are scrambled once the SOP beat is taken.
  task automatic applyStimulus(input int gapPct);
    bit accepted;
    int waitCnt;
    for (int b = 0; b < inQ.size(); b++) begin
      while ($urandom_range(99) < gapPct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = inQ[b].data;
      in_sop   = inQ[b].sop;
      in_eop   = inQ[b].eop;
      in_empty = inQ[b].empty;
      if (b == 0) begin
        hdr_data = curHdr;
        hdr_len  = curLen;
      end
      accepted = 1'b0;
      waitCnt  = 0;
      while (!accepted) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk); #1;
        waitCnt++;
        if (!accepted && waitCnt > 400) begin
          checkOutput("in_accept_timeout", 32'(accepted), 32'd1);
          in_valid = 1'b0;
          return;
        end
      end
      if (b == 0) begin
        hdr_data = {$urandom, $urandom};
        hdr_len  = 4'($urandom_range(15));
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 1000 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain_left", 32'(expQ.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic setPayload(input logic [7:0] base, input int n);
    payQ.delete();
    for (int i = 0; i < n; i++) payQ.push_back(base + 8'(i));
  endtask

  initial begin
    beat_t       e;
    logic [31:0] mask;
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_empty = '0; in_data = '0; hdr_data = '0; hdr_len = '0; out_ready = 1'b0;

    fork
      forever begin
        @(posedge clk); #1;
        case (readyMode)
          0:       out_ready = ($urandom_range(99) < 70);
          1:       out_ready = 1'b1;
          2:       out_ready = ~out_ready;
          default: out_ready = 1'b0;
        endcase
      end
      forever begin
        @(negedge clk);
        if (monEn && !rst) begin
          checkOutput("err_sop_idle", 32'(err_sop), 32'd0);
          if (trackEn && in_valid && out_valid)
            checkOutput("in_ready_track", 32'(in_ready), 32'(out_ready));
          if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
              checkOutput("spurious_beat", 32'(out_valid), 32'd0);
            end else begin
              e    = expQ.pop_front();
              mask = 32'hFFFF_FFFF;
              if (e.eop) mask = ~(mask >> (8 * (NB - int'(e.empty))));
              checkOutput("out_data", out_data & mask, e.data & mask);
              checkOutput("out_sop", 32'(out_sop), 32'(e.sop));
              checkOutput("out_eop", 32'(out_eop), 32'(e.eop));
              checkOutput("out_empty", 32'(out_empty), 32'(e.empty));
            end
          end
        end
      end
    join_none

    // Reset values, with out_ready high to show in_ready is still held low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sop", 32'(out_sop), 32'd0);
    checkOutput("rst_out_eop", 32'(out_eop), 32'd0);
    checkOutput("rst_out_empty", 32'(out_empty), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_err_sop", 32'(err_sop), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    monEn = 1'b1;
    @(posedge clk); #1;

    curHdr = 64'hC0C1_C2C3_C4C5_C6C7;

    // L=8, two payload beats: header beats pass whole.
    curLen = 4'd8; setPayload(8'h10, 8); buildPacket();
    checkOutput("pin8_beats", 32'(expQ.size()), 32'd4);
    checkOutput("pin8_b0", expQ[0].data, 32'hC0C1C2C3);
    checkOutput("pin8_b3", expQ[3].data, 32'h14151617);
    applyStimulus(0); waitDrain();

    // L=6, single beat: needs a flush beat.
    curLen = 4'd6; setPayload(8'hA0, 4); buildPacket();
    checkOutput("pin6_beats", 32'(expQ.size()), 32'd3);
    checkOutput("pin6_b1", expQ[1].data, 32'hC4C5A0A1);
    checkOutput("pin6_b2", expQ[2].data, 32'hA2A30000);
    checkOutput("pin6_empty", 32'(expQ[2].empty), 32'd2);
    applyStimulus(0); waitDrain();

    // L=3 with two payload bytes, then L=2 with the same payload.
    curLen = 4'd3; setPayload(8'hB0, 2); buildPacket();
    checkOutput("pin3_beats", 32'(expQ.size()), 32'd2);
    checkOutput("pin3_b0", expQ[0].data, 32'hC0C1C2B0);
    checkOutput("pin3_b1", expQ[1].data, 32'hB1000000);
    checkOutput("pin3_empty", 32'(expQ[1].empty), 32'd3);
    applyStimulus(0); waitDrain();
    curLen = 4'd2; setPayload(8'hB0, 2); buildPacket();
    checkOutput("pin2_beats", 32'(expQ.size()), 32'd1);
    checkOutput("pin2_b0", expQ[0].data, 32'hC0C1B0B1);
    checkOutput("pin2_empty", 32'(expQ[0].empty), 32'd0);
    applyStimulus(0); waitDrain();

    // L=0 passthrough with out_ready toggling.
    readyMode = 2; trackEn = 1'b1;
    curLen = 4'd0; setPayload(8'h50, 12); buildPacket();
    applyStimulus(0); waitDrain();
    trackEn = 1'b0; readyMode = 1;

    // L=8 with downstream stalled on the first header beat.
    readyMode = 3;
    @(posedge clk); #1;
    curLen = 4'd8; setPayload(8'h60, 4); buildPacket();
    fork
      applyStimulus(0);
      begin
        int w;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 50);
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          checkOutput("stall_data", out_data, 32'hC0C1C2C3);
          checkOutput("stall_sop", 32'(out_sop), 32'd1);
          checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        end
        readyMode = 1;
      end
    join
    waitDrain();

    // Header length above the maximum is clamped to 8.
    curLen = 4'd13; setPayload(8'h70, 5); buildPacket();
    applyStimulus(20); waitDrain();

    // Reset in the middle of a 3-beat packet (L=2).
    monEn = 1'b0;
    hdr_data = curHdr; hdr_len = 4'd2;
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_empty = '0; in_data = 32'hD0D1D2D3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_sop = 1'b0; in_data = 32'hD4D5D6D7; rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", out_data, 32'd0);
    checkOutput("midrst_out_sop", 32'(out_sop), 32'd0);
    checkOutput("midrst_out_eop", 32'(out_eop), 32'd0);
    checkOutput("midrst_out_empty", 32'(out_empty), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("discard1_err_sop", 32'(err_sop), 32'd1);
    checkOutput("discard1_in_ready", 32'(in_ready), 32'd1);
    checkOutput("discard1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_eop = 1'b1; in_data = 32'hD8D9DADB;
    @(negedge clk);
    checkOutput("discard2_err_sop", 32'(err_sop), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_eop = 1'b0;
    @(negedge clk);
    checkOutput("after_discard_err_sop", 32'(err_sop), 32'd0);
    @(posedge clk); #1;
    monEn = 1'b1;
    curLen = 4'd5; setPayload(8'h80, 7); buildPacket();
    applyStimulus(0); waitDrain();

    // Randomized packets back to back, random stalls and gaps.
    for (int p = 0; p < 40; p++) begin
      curHdr    = {$urandom, $urandom};
      curLen    = 4'($urandom_range(15));
      readyMode = (p % 3 == 0) ? 1 : 0;
      payQ.delete();
      for (int i = 0; i < int'($urandom_range(1, 14)); i++) payQ.push_back(8'($urandom));
      buildPacket();
      applyStimulus((p % 5 == 0) ? 0 : 30);
    end
    readyMode = 0;
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
